// File: rtl/requant_unit.sv
// requant_unit: int8 requantization stage behind the 4x4 matmul engine.
// Reads int32 accumulator words (4 lanes), applies bias, fixed-point
// multiply, rounding shift, zero point and clamp, writes packed int8.
// Optional build macro: REQUANT_BIAS_EN (bias read and add).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid, M, N    start pulse and matrix dimensions
//   out_mult/shift    quantized multiplier and signed shift
//   out_offset        output zero point
//   act_min/max       output clamp range
//   busy, done        status; done is a one-cycle pulse
//   C_index/C_data_out  accumulator read port (1-cycle latency)
//   B_index/B_data_out  bias read port (1-cycle latency)
//   O_wr_en/O_index/O_data_in  packed int8 output write port
module requant_unit #(
    parameter int IDX_W = 16,
    parameter int DIM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DIM_W-1:0] M,
    input  logic [DIM_W-1:0] N,
    input  logic [31:0]      out_mult,
    input  logic [5:0]       out_shift,
    input  logic [8:0]       out_offset,
    input  logic [7:0]       act_min,
    input  logic [7:0]       act_max,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] C_index,
    input  logic [127:0]     C_data_out,
    output logic [IDX_W-1:0] B_index,
    input  logic [127:0]     B_data_out,
    output logic             O_wr_en,
    output logic [IDX_W-1:0] O_index,
    output logic [31:0]      O_data_in
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [DIM_W-1:0] m_last;
    logic [DIM_W-1:0] g_last;
    logic [DIM_W-1:0] n_r;
    logic [DIM_W-1:0] m_cnt;
    logic [DIM_W-1:0] g_cnt;
    logic [31:0]      mult_r;
    logic [5:0]       shift_r;
    logic [8:0]       offset_r;
    logic [7:0]       min_r;
    logic [7:0]       max_r;

    logic [4:0] lsh;
    logic [4:0] rsh;
    logic       accept;
    logic [3:0] lane_ok;

    logic             d_v;
    logic             s1_v;
    logic             s2_v;
    logic [IDX_W-1:0] d_w;
    logic [IDX_W-1:0] s1_w;
    logic [IDX_W-1:0] s2_w;
    logic [3:0]       d_mask;
    logic [3:0]       s1_mask;
    logic [3:0]       s2_mask;
    logic [3:0][31:0] s1_sum;
    logic [3:0][31:0] s1_x;
    logic [3:0][31:0] s2_y;

    // A new job may start as soon as busy is low, including the DONE cycle.
    assign accept = in_valid && (state == IDLE || state == DONE);

    // Signed shift split into a left amount and a right amount.
    assign lsh = shift_r[5] ? 5'd0 : shift_r[4:0];
    assign rsh = shift_r[5] ? (~shift_r[4:0] + 5'd1) : 5'd0;

    // Lane i of group g holds column 4g+i; columns past N are zeroed.
    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < 4; i++) begin
            lane_ok[i] = ({g_cnt, 2'(i)} < {2'b00, n_r});
        end
    end

`ifdef REQUANT_BIAS_EN
    assign B_index = IDX_W'(g_cnt);

    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < 4; i++) begin
            s1_sum[i] = C_data_out[32*i +: 32] + B_data_out[32*i +: 32];
        end
    end
`else
    logic unused_bias;

    assign B_index     = '0;
    assign unused_bias = ^B_data_out;

    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < 4; i++) begin
            s1_sum[i] = C_data_out[32*i +: 32];
        end
    end
`endif

    // Saturating rounding doubling high multiply (gemmlowp SRDHM).
    function automatic logic [31:0] srdhm(
        input logic [31:0] x,
        input logic [31:0] m
    );
        logic [63:0] p;
        logic [63:0] q;
        if (x == 32'h8000_0000 && m == 32'h8000_0000) begin
            return 32'h7fff_ffff;
        end
        p = {{32{x[31]}}, x} * {{32{m[31]}}, m};
        q = p + (p[63] ? 64'hffff_ffff_c000_0001
                       : 64'h0000_0000_4000_0000);
        // Bias negatives so the shift truncates toward zero.
        if (q[63]) begin
            q = q + 64'h0000_0000_7fff_ffff;
        end
        return q[62:31];
    endfunction

    // Rounding right shift, zero point and clamp to int8.
    function automatic logic [7:0] finish_lane(
        input logic [31:0] y,
        input logic [4:0]  e,
        input logic [8:0]  off,
        input logic [7:0]  lo,
        input logic [7:0]  hi
    );
        logic [31:0]        mask;
        logic [31:0]        r;
        logic [31:0]        th;
        logic [31:0]        z;
        logic signed [33:0] o;
        logic signed [33:0] lo_s;
        logic signed [33:0] hi_s;
        mask = (32'd1 << e) - 32'd1;
        r    = y & mask;
        th   = (mask >> 1) + {31'd0, y[31]};
        z    = $signed(y) >>> e;
        z    = z + {31'd0, (r > th)};
        o    = {{2{z[31]}}, z} + {{25{off[8]}}, off};
        lo_s = {{26{lo[7]}}, lo};
        hi_s = {{26{hi[7]}}, hi};
        // Upper bound applied last so an inverted range yields act_max.
        if (o < lo_s) begin
            o = lo_s;
        end
        if (o > hi_s) begin
            o = hi_s;
        end
        return o[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            C_index  <= '0;
            m_cnt    <= '0;
            g_cnt    <= '0;
            m_last   <= '0;
            g_last   <= '0;
            n_r      <= '0;
            mult_r   <= '0;
            shift_r  <= '0;
            offset_r <= '0;
            min_r    <= '0;
            max_r    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        m_last   <= M - DIM_W'(1);
                        g_last   <= (N - DIM_W'(1)) >> 2;
                        n_r      <= N;
                        mult_r   <= out_mult;
                        shift_r  <= out_shift;
                        offset_r <= out_offset;
                        min_r    <= act_min;
                        max_r    <= act_max;
                        m_cnt    <= '0;
                        g_cnt    <= '0;
                        C_index  <= '0;
                        if (M == '0 || N == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (m_cnt == m_last && g_cnt == g_last) begin
                        state <= DRAIN;
                    end else begin
                        C_index <= C_index + IDX_W'(1);
                        if (m_cnt == m_last) begin
                            m_cnt <= '0;
                            g_cnt <= g_cnt + DIM_W'(1);
                        end else begin
                            m_cnt <= m_cnt + DIM_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!d_v && !s1_v && !s2_v) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid chain and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_v       <= 1'b0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            O_wr_en   <= 1'b0;
            O_index   <= '0;
            O_data_in <= '0;
        end else begin
            d_v     <= (state == RUN);
            s1_v    <= d_v;
            s2_v    <= s1_v;
            O_wr_en <= s2_v;
            if (s2_v) begin
                O_index <= s2_w;
                for (int i = 0; i < 4; i++) begin
                    O_data_in[8*i +: 8] <= s2_mask[i]
                        ? finish_lane(s2_y[i], rsh, offset_r,
                                      min_r, max_r)
                        : 8'h00;
                end
            end
        end
    end

    // Datapath payload; qualified by the valid chain above.
    always_ff @(posedge clk) begin
        d_w     <= C_index;
        d_mask  <= lane_ok;
        s1_w    <= d_w;
        s1_mask <= d_mask;
        s2_w    <= s1_w;
        s2_mask <= s1_mask;
        for (int i = 0; i < 4; i++) begin
            s1_x[i] <= s1_sum[i] << lsh;
            s2_y[i] <= srdhm(s1_x[i], mult_r);
        end
    end

endmodule

// File: tb/tb_requant_unit.sv
// tb_requant_unit: scoreboard bench for requant_unit.
// Random and directed jobs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_requant_unit;

    localparam int IDX_W = 16;
    localparam int DIM_W = 10;
    localparam int IMIN  = -2147483647 - 1;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic [DIM_W-1:0] m_i      = '0;
    logic [DIM_W-1:0] n_i      = '0;
    logic [31:0]      mult_i   = '0;
    logic [5:0]       shift_i  = '0;
    logic [8:0]       off_i    = '0;
    logic [7:0]       amin_i   = '0;
    logic [7:0]       amax_i   = '0;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] C_index;
    logic [IDX_W-1:0] B_index;
    logic [IDX_W-1:0] O_index;
    logic [127:0]     C_data_out = '0;
    logic [127:0]     B_data_out = '0;
    logic             O_wr_en;
    logic [31:0]      O_data_in;

    logic [127:0] C_mem [0:63];
    logic [127:0] B_mem [0:15];

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks     = 0;
    int          errors     = 0;
    int          cur_m      = 1;
    int          cur_w      = 0;
    bit          mon_en     = 1'b0;
    int          bc         = 0;
    logic [31:0] last_wdata = '0;

    always #5 clk = ~clk;

    requant_unit #(.IDX_W(IDX_W), .DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .M          (m_i),
        .N          (n_i),
        .out_mult   (mult_i),
        .out_shift  (shift_i),
        .out_offset (off_i),
        .act_min    (amin_i),
        .act_max    (amax_i),
        .busy       (busy),
        .done       (done),
        .C_index    (C_index),
        .C_data_out (C_data_out),
        .B_index    (B_index),
        .B_data_out (B_data_out),
        .O_wr_en    (O_wr_en),
        .O_index    (O_index),
        .O_data_in  (O_data_in)
    );

    // Buffer models with one cycle of read latency.
    always @(posedge clk) begin
        C_data_out <= C_mem[C_index[5:0]];
        B_data_out <= B_mem[B_index[3:0]];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h",
                     name, $time, act, expv);
        end
    endtask

    // Reference lane: plain integer arithmetic from the requant rules.
    function automatic logic [7:0] ref_lane(int acc, int bias, int mult,
                                            int sh, int off, int lo,
                                            int hi);
        int     x;
        int     y;
        int     e;
        longint p;
        longint z;
        longint a;
        longint o;
        x = acc + bias;
        if (sh > 0) x = x << sh;
        if (x == IMIN && mult == IMIN) begin
            y = 2147483647;
        end else begin
            p = longint'(x) * longint'(mult);
            if (p >= 0) p = p + 1073741824;
            else        p = p + 1 - 1073741824;
            y = int'(p / (longint'(1) << 31));
        end
        e = (sh < 0) ? -sh : 0;
        if (e == 0) begin
            z = y;
        end else begin
            // round half away from zero
            a = (y < 0) ? -longint'(y) : longint'(y);
            z = (a + (longint'(1) << (e - 1))) >> e;
            if (y < 0) z = -z;
        end
        o = z + off;
        if (o < lo) o = lo;
        if (o > hi) o = hi;
        return o[7:0];
    endfunction

    // Monitor: read ordering, write data/order/latency, busy length.
    always @(negedge clk) begin
        exp_t e;
        if (busy) bc++;
        if (mon_en && !rst) begin
            if (busy && bc <= cur_w) begin
                chk("c_index", C_index, bc - 1);
`ifdef REQUANT_BIAS_EN
                chk("b_index", B_index, (bc - 1) / cur_m);
`else
                chk("b_index", B_index, 0);
`endif
            end
            if (O_wr_en) begin
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("o_index", O_index, e.idx);
                    chk("o_data", O_data_in, e.data);
                    chk("write_lat", bc, e.idx + 5);
                end
                last_wdata = O_data_in;
            end
            if (!busy && bc != 0) begin
                chk("busy_len", bc, cur_w + 4);
                chk("done_at_end", done, 1);
            end
        end
        if (!busy) bc = 0;
    end

    task automatic run_job(input int m, input int n, input int mult,
                           input int sh, input int off, input int lo,
                           input int hi, input bit poke);
        int          g_n;
        int          w_n;
        int          k;
        int          b;
        exp_t        e;
        logic [31:0] word;
        g_n = (n + 3) / 4;
        w_n = m * g_n;
        for (int w = 0; w < w_n; w++) begin
            int g;
            g    = w / m;
            word = '0;
            for (int i = 0; i < 4; i++) begin
                b = 0;
`ifdef REQUANT_BIAS_EN
                b = int'(B_mem[g][32*i +: 32]);
`endif
                if (4 * g + i < n)
                    word[8*i +: 8] = ref_lane(int'(C_mem[w][32*i +: 32]),
                                              b, mult, sh, off, lo, hi);
            end
            e.idx  = IDX_W'(w);
            e.data = word;
            exp_q.push_back(e);
        end
        cur_m = m;
        cur_w = w_n;
        @(negedge clk);
        m_i      = DIM_W'(m);
        n_i      = DIM_W'(n);
        mult_i   = mult;
        shift_i  = 6'(sh);
        off_i    = 9'(off);
        amin_i   = 8'(lo);
        amax_i   = 8'(hi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!done && k < w_n + 20) begin
            @(negedge clk);
            k++;
            if (poke && k == 2) begin
                in_valid = 1'b1;
                m_i      = DIM_W'(3);
                n_i      = DIM_W'(9);
                mult_i   = 32'h1234_5678;
            end
            if (k == 3) in_valid = 1'b0;
        end
        chk("done_latency", k, (w_n == 0) ? 0 : w_n + 4);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic clear_mem();
        for (int w = 0; w < 64; w++) C_mem[w] = '0;
        for (int g = 0; g < 16; g++) B_mem[g] = '0;
    endtask

    task automatic rand_mem();
        for (int w = 0; w < 64; w++)
            for (int i = 0; i < 4; i++)
                C_mem[w][32*i +: 32] = $urandom_range(0, 1)
                    ? $urandom
                    : 32'($urandom_range(0, 4000)) - 32'd2000;
        for (int g = 0; g < 16; g++)
            for (int i = 0; i < 4; i++)
                B_mem[g][32*i +: 32] =
                    32'($urandom_range(0, 400)) - 32'd200;
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", O_wr_en, 0);
        chk("rst_c_index", C_index, 0);
        chk("rst_b_index", B_index, 0);
        chk("rst_o_index", O_index, 0);
        chk("rst_o_data", O_data_in, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // lane math
        C_mem[0] = {-32'sd300, 32'sd300, -32'sd100, 32'sd100};
        run_job(1, 4, 32'h4000_0000, 0, -128, -128, 127, 1'b0);
        chk("lane_math", last_wdata, 32'h8016_80B2);

        // rounding with right shift
        C_mem[0] = {32'sd0, 32'sd0, -32'sd5, 32'sd5};
        run_job(1, 2, 32'h4000_0000, -1, 0, -128, 127, 1'b0);
        chk("rounding", last_wdata, 32'h0000_FF02);

        // SRDHM saturation corner
        C_mem[0] = {32'd0, 32'd0, 32'd0, 32'h8000_0000};
        run_job(1, 1, IMIN, 0, 0, -128, 127, 1'b0);
        chk("saturation", last_wdata, 32'h0000_007F);

        // inverted clamp range gives act_max
        C_mem[0] = {32'sd7, -32'sd9000, 32'sd9000, 32'sd0};
        run_job(1, 4, 32'h4000_0000, 0, 0, 10, -10, 1'b0);
        chk("inv_clamp", last_wdata, 32'hF6F6_F6F6);

        // bias path
        C_mem[0] = '0;
        B_mem[0] = {32'sd0, 32'sd0, -32'sd10, 32'sd10};
        run_job(1, 4, 32'h7FFF_FFFF, 0, 0, -128, 127, 1'b0);
`ifdef REQUANT_BIAS_EN
        chk("bias", last_wdata, 32'h0000_F60A);
`else
        chk("bias", last_wdata, 32'h0000_0000);
`endif
        B_mem[0] = '0;

        // layout and column masking
        rand_mem();
        run_job(2, 6, 32'h4000_0000, -2, 3, -128, 127, 1'b0);
        chk("layout_mask", last_wdata[31:16], 16'h0000);

        // empty jobs
        run_job(0, 4, 32'h4000_0000, 0, 0, -128, 127, 1'b0);
        run_job(3, 0, 32'h4000_0000, 0, 0, -128, 127, 1'b0);

        // in_valid while busy is ignored
        rand_mem();
        run_job(3, 8, 32'h5000_0000, -3, -5, -100, 100, 1'b1);

        // random jobs
        for (int j = 0; j < 30; j++) begin
            int m;
            int n;
            int sh;
            int off;
            int lo;
            int hi;
            int t;
            int mult;
            rand_mem();
            m    = $urandom_range(1, 8);
            n    = $urandom_range(1, 32);
            mult = $urandom_range(0, 1)
                 ? int'($urandom)
                 : int'(32'h4000_0000 + $urandom_range(0, 32'h2000_0000));
            sh   = $urandom_range(0, 3) == 0
                 ? int'($urandom_range(0, 62)) - 31
                 : int'($urandom_range(0, 14)) - 12;
            off  = int'($urandom_range(0, 511)) - 256;
            lo   = int'($urandom_range(0, 255)) - 128;
            hi   = int'($urandom_range(0, 255)) - 128;
            if (j % 4 != 3 && lo > hi) begin
                t  = lo;
                lo = hi;
                hi = t;
            end
            run_job(m, n, mult, sh, off, lo, hi, (j % 5) == 0);
        end

        // reset in the middle of a run
        mon_en = 1'b0;
        rand_mem();
        @(negedge clk);
        m_i      = DIM_W'(4);
        n_i      = DIM_W'(16);
        mult_i   = 32'h4000_0000;
        shift_i  = '0;
        off_i    = '0;
        amin_i   = 8'h80;
        amax_i   = 8'h7F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_run_write", O_wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wr", O_wr_en, 0);
        chk("rst_mid_done", done, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_quiet_wr", O_wr_en, 0);
            chk("rst_quiet_busy", busy, 0);
        end
        mon_en = 1'b1;

        // recovery after reset
        rand_mem();
        run_job(5, 13, 32'h6000_0000, -4, 17, -90, 90, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/requant_unit.md
Name: requant_unit

Overview:
- Post-processing stage directly downstream of the 4x4 systolic matmul engine.
- Walks the engine's 128-bit int32 accumulator buffer (C) and applies TFLite-style int8 requantization to 4 lanes per word: optional bias, fixed-point multiply, rounding shift, output offset and clamp.
- Writes packed int8 results (4 per 32-bit word) to the activation output buffer that feeds the next layer.
- Streams at 1 word/cycle.

Parameters:
- IDX_W, 16: width of all buffer index ports.
- DIM_W, 10: width of the M and N dimension inputs.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  start pulse; accepted only when busy=0
- M  in  DIM_W  rows
- N  in  DIM_W  columns
- out_mult  in  32  signed quantized multiplier
- out_shift  in  6  signed; >0 left shift, <0 right shift; range -31..31
- out_offset  in  9  signed output zero point
- act_min  in  8  signed clamp low
- act_max  in  8  signed clamp high
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse on completion
- C_index  out  IDX_W  accumulator read address
- C_data_out  in  128  accumulator word; lane i at bits [32i+31:32i]; valid 1 cycle after C_index
- B_index  out  IDX_W  bias read address (column group g)
- B_data_out  in  128  4 int32 biases, same lane order, 1-cycle latency
- O_wr_en  out  1  output write strobe
- O_index  out  IDX_W  output write address
- O_data_in  out  32  4 int8 results; lane i at bits [8i+7:8i]

Behaviour:
- Reset values: busy=0, done=0, O_wr_en=0, C_index=0, B_index=0, O_index=0, O_data_in=0. Pipeline valid bits are cleared.
- Reset mid-operation: no write occurs in any cycle after rst is sampled high. The FSM returns to IDLE.
- On in_valid with busy=0, latch all configuration inputs. in_valid while busy=1 is ignored.
- Word count W = M*G, where G = ceil(N/4). Word w corresponds to g = w / M and m = w % M; this matches the engine's column-group-major C layout. Lane i is column 4g+i. Lanes with column >= N produce byte 0x00.
- FSM states:
  - IDLE -> RUN on accept; -> DONE on accept if W==0 (no reads, no writes).
  - RUN: present C_index=w and B_index=g, with w incrementing each cycle from 0 to W-1; -> DRAIN after issuing W-1.
  - DRAIN: wait until the pipeline is empty; -> DONE.
  - DONE: done=1 and busy=0 in this cycle; -> IDLE.
- Pipeline, per lane, in order; stages S1-S3 are registered:
  - Read cycle: C_index presented.
  - Data return: C_data_out and B_data_out valid.
  - S1: x = acc + bias, 32-bit wrap; then x <<= max(shift,0), 32-bit wrap.
  - S2: y = SRDHM(x, mult). If x == mult == -2^31, y = 2^31-1. Otherwise p = x*mult (64-bit) plus nudge, where nudge = 2^30 if p>=0 else 1-2^30; y = p / 2^31, truncating toward zero.
  - S3: e = max(-shift,0); mask = 2^e-1; r = y & mask; th = (mask>>1) + (y<0); z = (y>>>e) + (r>th). Then o = z + out_offset and clamp to [act_min, act_max].
- O_wr_en is asserted 4 cycles after the corresponding C_index was presented, with O_index = w. Writes occur in ascending w order, one per cycle, with no gaps.
- busy cycles = W + 4; done is asserted the cycle after the last write.
- act_min > act_max is not checked; the result equals act_max.

Optional Feature:
- Macro REQUANT_BIAS_EN.
- Defined: bias is read and added as specified.
- Undefined: bias is treated as 0 in every lane, B_index is tied to 0, B_data_out is ignored, and the S1 adder is removed. Latency is unchanged.

Test Plan:
- Lane math: M=1, N=4, mult=0x40000000, shift=0, offset=-128, clamp [-128,127], bias 0, C lanes {100,-100,300,-300} -> single write O_index=0, O_data_in=0x801680B2.
- Rounding: M=1, N=2, mult=0x40000000, shift=-1, offset=0, lanes {5,-5} -> bytes {0x02,0xFF,0x00,0x00}, O_data_in=0x0000FF02.
- Saturation: mult=0x80000000, shift=0, acc=0x80000000, clamp [-128,127] -> lane byte 0x7F.
- Layout and masking: M=2, N=6 -> reads C_index 0,1,2,3 on consecutive cycles; B_index 0,0,1,1; writes O_index 0..3, each exactly 4 cycles after its read; lanes 2-3 of words 2-3 are 0x00; busy high for 8 cycles then done.
- Control: start with M=0 -> done on the following cycle, no O_wr_en. in_valid pulsed while busy -> no effect. rst asserted mid-RUN -> O_wr_en=0 from the next cycle, busy=0.
- With REQUANT_BIAS_EN: bias lanes {10,-10,0,0}, acc {0,0,0,0}, mult=0x7FFFFFFF, shift=0, offset 0 -> bytes {0x0A,0xF6,0x00,0x00}. Without the macro, same stimulus -> 0x00000000.
